// File: rtl/avst_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module   : avst_symbol_packer
// Brief    : Packs a one-symbol-per-cycle Avalon-ST stream into multi-symbol
//            beats, lane 0 (MSB) first, with sop/eop/empty framing.
// Revision : 1.0 - initial release
// ============================================================================
module avst_symbol_packer #(
    parameter int  BITS_PER_SYMBOL  = 20,
    parameter int  SYMBOL_PER_BEATS = 4,
    localparam int EMPTY_W          = $clog2(SYMBOL_PER_BEATS)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [BITS_PER_SYMBOL-1:0]              in_data,
    input  logic                                    in_sop,
    input  logic                                    in_eop,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [BITS_PER_SYMBOL*SYMBOL_PER_BEATS-1:0] out_data,
    output logic                                    out_sop,
    output logic                                    out_eop,
    output logic [EMPTY_W-1:0]                      out_empty,
    output logic                                    err_pulse,
    output logic [31:0]                             pkt_cnt
);

    localparam int                C_BEAT_W    = BITS_PER_SYMBOL * SYMBOL_PER_BEATS;
    localparam logic [EMPTY_W-1:0] C_LAST_LANE = EMPTY_W'(SYMBOL_PER_BEATS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [EMPTY_W-1:0]    r_lane;
    logic [C_BEAT_W-1:0]   r_acc;
    logic                  r_first;
    logic                  r_out_valid;
    logic [C_BEAT_W-1:0]   r_out_data;
    logic                  r_out_sop;
    logic                  r_out_eop;
    logic [EMPTY_W-1:0]    r_out_empty;
    logic                  r_err;
    logic [31:0]           r_pkt_cnt;

    logic                  w_in_ready;
    logic                  w_sym_fire;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_complete;
    logic                  w_beat_sop;
    logic [EMPTY_W-1:0]    w_lane;
    logic [C_BEAT_W-1:0]   w_merged;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_sym_fire = in_valid && w_in_ready;
    assign w_start    = w_sym_fire && (r_state == S_IDLE) && in_sop;
    // Symbols outside a packet are dropped; a stray sop inside one is only flagged.
    assign w_accept   = w_sym_fire && ((r_state == S_IN_PKT) || in_sop);
    assign w_err      = w_sym_fire && ((r_state == S_IDLE) ? !in_sop : in_sop);
    assign w_lane     = w_start ? '0 : r_lane;
    assign w_complete = w_accept && (in_eop || (w_lane == C_LAST_LANE));
    assign w_beat_sop = w_start || r_first;

    always_comb begin
        w_merged = w_start ? '0 : r_acc;
        for (int i = 0; i < SYMBOL_PER_BEATS; i++) begin
            if (w_lane == EMPTY_W'(i)) begin
                w_merged[(SYMBOL_PER_BEATS-1-i)*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = in_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = in_eop ? S_IDLE : S_IN_PKT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_acc       <= '0;
            r_first     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
            r_err       <= 1'b0;
            r_pkt_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;

            if (w_accept) begin
                if (w_complete) begin
                    r_acc   <= '0;
                    r_lane  <= '0;
                    r_first <= 1'b0;
                end else begin
                    r_acc   <= w_merged;
                    r_lane  <= w_lane + EMPTY_W'(1);
                    r_first <= w_beat_sop;
                end
            end

            // A completing fire implies the output register is free or draining.
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_merged;
                r_out_sop   <= w_beat_sop;
                r_out_eop   <= in_eop;
                r_out_empty <= C_LAST_LANE - w_lane;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (r_out_valid && out_ready && r_out_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign out_empty = r_out_empty;
    assign err_pulse = r_err;
    assign pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire

// File: doc/avst_symbol_packer.md
AVST_SYMBOL_PACKER -- requirements
Module: avst_symbol_packer

Interface
REQ-001 SHALL have parameter BITS_PER_SYMBOL, default 20, giving the width of one symbol.
REQ-002 SHALL have parameter SYMBOL_PER_BEATS, default 4, giving symbols per output beat; legal values are 2 or more.
REQ-003 SHALL derive EMPTY_W = clog2(SYMBOL_PER_BEATS) as a localparam.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  upstream symbol valid.
REQ-008 in_ready  output  1  packer accepts a symbol this cycle.
REQ-009 in_data  input  BITS_PER_SYMBOL  one symbol.
REQ-010 in_sop  input  1  first symbol of a packet.
REQ-011 in_eop  input  1  last symbol of a packet.
REQ-012 out_valid  output  1  packed beat valid.
REQ-013 out_ready  input  1  downstream (dc_fifo_wrapper_infill input) accepts the beat.
REQ-014 out_data  output  BITS_PER_SYMBOL*SYMBOL_PER_BEATS  packed beat.
REQ-015 out_sop  output  1  beat holds the packet's first symbol.
REQ-016 out_eop  output  1  beat holds the packet's last symbol.
REQ-017 out_empty  output  EMPTY_W  count of unused symbol lanes; nonzero only when out_eop=1.
REQ-018 err_pulse  output  1  one-cycle protocol-error strobe.
REQ-019 pkt_cnt  output  32  count of beats emitted with out_eop=1; wraps at 2^32.

Function
REQ-020 SHALL define symbol fire as in_valid && in_ready, and beat fire as out_valid && out_ready.
REQ-021 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-022 SHALL implement FSM IDLE/IN_PKT: IDLE->IN_PKT on a fire with in_sop=1 and in_eop=0; IN_PKT->IDLE on a fire with in_eop=1; a fire with sop=eop=1 in IDLE stays IDLE.
REQ-023 SHALL place the packet's first symbol in lane 0 = out_data[MSB -: BITS_PER_SYMBOL], with later symbols in descending lanes.
REQ-024 SHALL keep a lane index; it resets to 0 at each beat completion and at packet start.
REQ-025 SHALL complete a beat on a fire that fills lane SYMBOL_PER_BEATS-1 or that carries in_eop=1.
REQ-026 SHALL load the completed beat into the output register in the cycle after the completing fire: out_valid=1, out_empty = SYMBOL_PER_BEATS - filled lanes, unfilled lanes = 0.
REQ-027 SHALL set out_sop=1 only on the first beat of a packet, and out_eop=1 only on the beat completed by in_eop.
REQ-028 SHALL hold out_valid, out_data, out_sop, out_eop and out_empty stable until beat fire.
REQ-029 SHALL clear out_valid on a beat fire unless a new beat completes in that same cycle, in which case the new beat loads back-to-back.
REQ-030 SHALL sustain one symbol per cycle while out_ready=1.
REQ-031 SHALL, in IDLE on a fire with in_sop=0: drop the symbol, pulse err_pulse, keep in_ready high, produce no output.
REQ-032 SHALL, in IN_PKT on a fire with in_sop=1: pulse err_pulse and treat the symbol as a continuation, with sop ignored and no out_sop.
REQ-033 SHALL increment pkt_cnt on each beat fire with out_eop=1.

Reset
REQ-034 SHALL, while rst=1: out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0, err_pulse=0, pkt_cnt=0, FSM=IDLE, lane index=0, partial beat discarded.
REQ-035 SHALL, when rst is asserted mid-packet, drop the partial packet with no output and begin cleanly on the next in_sop.

Verification
REQ-036 With BITS=20, N=4, out_ready=1, an 8-symbol packet 1..8 SHALL give beats {1,2,3,4} (sop=1, eop=0, empty=0) then {5,6,7,8} (sop=0, eop=1, empty=0), with pkt_cnt=1.
REQ-037 A 5-symbol packet 1..5 SHALL give {1,2,3,4} (sop=1), then {5,0,0,0} (eop=1, empty=3).
REQ-038 A single symbol 0xABCDE with sop=eop=1 SHALL give one beat {0xABCDE,0,0,0} (sop=eop=1, empty=3), and the FSM SHALL remain IDLE.
REQ-039 out_ready=0 for 10 cycles after the first beat of an 8-symbol packet SHALL hold in_ready=0 with the beat stable; on release, all 8 symbols SHALL arrive in order with no loss or duplication.
REQ-040 A symbol 0x7 without sop in IDLE SHALL give err_pulse=1 for 1 cycle and no output; a sop on symbol 3 of a 4-symbol packet SHALL give err_pulse=1 and one beat {1,2,3,4} (sop=1, eop=1).
REQ-041 rst asserted after 2 symbols SHALL give out_valid=0; a following 4-symbol packet 9..12 SHALL give {9,10,11,12} (sop=1, eop=1, empty=0).
